// File: rtl/ro_puf_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// ro_puf_seq_ctrl_if : control/status bundle of the RO-PUF sequencer.
// Rev 1.0
// ============================================================================
interface ro_puf_seq_ctrl_if #(
  parameter int N_BITS = 256,
  parameter int REF_W  = 8
);
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  logic             start;
  logic             cont;
  logic             abort;
  logic [REF_W-1:0] win_len;
  logic             lfsr_dv;
  logic             lfsr_en;
  logic             ro_en;
  logic             count_en;
  logic             ref_en;
  logic             sr_en;
  logic             count_reset;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [BIT_W-1:0] bit_idx;
  logic [REF_W-1:0] ref_cnt;

  modport master (
    output start, cont, abort, win_len,
    input  lfsr_dv, lfsr_en, ro_en, count_en, ref_en, sr_en, count_reset,
           busy, done, aborted, bit_idx, ref_cnt
  );

  modport slave (
    input  start, cont, abort, win_len,
    output lfsr_dv, lfsr_en, ro_en, count_en, ref_en, sr_en, count_reset,
           busy, done, aborted, bit_idx, ref_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ro_puf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// ro_puf_seq_ctrl : parametrised RO-PUF run sequencer (settle/measure/capture).
// Rev 1.0
// ============================================================================
module ro_puf_seq_ctrl #(
  parameter int N_BITS     = 256,
  parameter int REF_W      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  ro_puf_seq_ctrl_if.slave    ctl
);
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_CAPTURE = 3'd4,
    S_CLEAR   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam state_e BIT_ENTRY = (SETTLE_CYC > 0) ? S_SETTLE : S_MEASURE;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [REF_W-1:0] win_q, win_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             busy_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      ref_q     <= '0;
      win_q     <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      ref_q     <= ref_d;
      win_q     <= win_d;
      settle_q  <= settle_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy_w = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    ref_d     = '0;
    win_d     = win_q;
    settle_d  = '0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          state_d = S_LOAD;
          win_d   = ctl.win_len;
          bit_d   = '0;
        end
      end
      S_LOAD:    state_d = BIT_ENTRY;
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_MEASURE;
        else                         settle_d = settle_q + SET_W'(1);
      end
      S_MEASURE: begin
        // Terminal compare before increment: win_len of all-ones never wraps.
        if (ref_q == win_q) state_d = S_CAPTURE;
        else                ref_d   = ref_q + REF_W'(1);
      end
      S_CAPTURE: state_d = S_CLEAR;
      S_CLEAR: begin
        if (bit_q == BIT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          state_d = BIT_ENTRY;
        end
      end
      S_DONE: begin
        if (ctl.start && ctl.cont) begin
          state_d = S_LOAD;
          win_d   = ctl.win_len;
          bit_d   = '0;
        end else if (!ctl.start) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase

    if (ctl.abort) begin
      state_d   = S_IDLE;
      bit_d     = '0;
      ref_d     = '0;
      win_d     = win_q;
      settle_d  = '0;
      done_d    = 1'b0;
      aborted_d = busy_w;
    end
  end

  always_comb begin
    ctl.lfsr_dv     = 1'b0;
    ctl.lfsr_en     = 1'b0;
    ctl.ro_en       = 1'b0;
    ctl.count_en    = 1'b0;
    ctl.ref_en      = 1'b0;
    ctl.sr_en       = 1'b0;
    ctl.count_reset = 1'b0;
    case (state_q)
      S_LOAD: begin
        ctl.lfsr_dv     = 1'b1;
        ctl.lfsr_en     = 1'b1;
        ctl.count_reset = 1'b1;
      end
      S_SETTLE: begin
        ctl.ro_en       = 1'b1;
        ctl.count_reset = 1'b1;
      end
      S_MEASURE: begin
        ctl.ro_en    = 1'b1;
        ctl.count_en = 1'b1;
        ctl.ref_en   = 1'b1;
      end
      S_CAPTURE: begin
        ctl.count_en = 1'b1;
        ctl.sr_en    = 1'b1;
        ctl.lfsr_en  = 1'b1;
      end
      S_CLEAR: begin
        ctl.count_en    = 1'b1;
        ctl.count_reset = 1'b1;
      end
      default:   ctl.count_reset = 1'b1;
    endcase
  end

  assign ctl.busy    = busy_w;
  assign ctl.done    = done_q;
  assign ctl.aborted = aborted_q;
  assign ctl.bit_idx = bit_q;
  assign ctl.ref_cnt = ref_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ro_puf_seq_ctrl : directed self-checking bench against a cycle model.
// Rev 1.0
// ============================================================================
module tb_ro_puf_seq_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ro_puf_seq_ctrl_if #(.N_BITS(4), .REF_W(8)) ifa ();
  ro_puf_seq_ctrl_if #(.N_BITS(4), .REF_W(8)) ifb ();

  ro_puf_seq_ctrl #(.N_BITS(4), .REF_W(8), .SETTLE_CYC(2)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (ifa)
  );

  ro_puf_seq_ctrl #(.N_BITS(4), .REF_W(8), .SETTLE_CYC(0)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {bit_idx, ref_cnt, lfsr_dv, lfsr_en, ro_en, count_en, ref_en, sr_en, count_reset, busy, done, aborted}
  logic [25:0] obs_a, obs_b;
  assign obs_a = {6'd0, ifa.bit_idx, ifa.ref_cnt, ifa.lfsr_dv, ifa.lfsr_en, ifa.ro_en,
                  ifa.count_en, ifa.ref_en, ifa.sr_en, ifa.count_reset, ifa.busy,
                  ifa.done, ifa.aborted};
  assign obs_b = {6'd0, ifb.bit_idx, ifb.ref_cnt, ifb.lfsr_dv, ifb.lfsr_en, ifb.ro_en,
                  ifb.count_en, ifb.ref_en, ifb.sr_en, ifb.count_reset, ifb.busy,
                  ifb.done, ifb.aborted};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs c cycles after the edge that sampled start (c=1 is LOAD).
  function automatic logic [25:0] model(input int c, input int s, input int w, input int n);
    int          per;
    int          last;
    int          p;
    int          bi;
    int          r;
    logic [9:0]  st;
    per  = s + w + 3;
    last = 1 + n * per;
    st   = 10'h008;
    bi   = 0;
    r    = 0;
    if (c == 1) begin
      st = 10'h30C;
    end else if (c >= 2 && c <= last) begin
      p  = (c - 2) % per;
      bi = (c - 2) / per;
      if (p < s)               st = 10'h08C;
      else if (p <= s + w) begin
        st = 10'h0E4;
        r  = p - s;
      end
      else if (p == s + w + 1) st = 10'h154;
      else                     st = 10'h04C;
    end else if (c > last) begin
      bi = n - 1;
      st = (c == last + 1) ? 10'h00A : 10'h008;
    end
    return {8'(bi), 8'(r), st};
  endfunction

  task automatic run_model(input string name, input bit sel_b, input int s, input int w,
                           input int n, input int ncyc);
    if (sel_b) begin
      ifb.win_len = 8'(w);
      ifb.start   = 1'b1;
    end else begin
      ifa.win_len = 8'(w);
      ifa.start   = 1'b1;
    end
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      check_eq($sformatf("%s c%0d", name, c), 32'(sel_b ? obs_b : obs_a), 32'(model(c, s, w, n)));
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int dcnt;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    {ifa.start, ifa.cont, ifa.abort} = 3'b000;
    {ifb.start, ifb.cont, ifb.abort} = 3'b000;
    ifa.win_len = 8'd0;
    ifb.win_len = 8'd0;
    tick();
    tick();
    check_eq("reset_a", 32'(obs_a), 32'h0000_0008);
    check_eq("reset_b", 32'(obs_b), 32'h0000_0008);
    rst_n = 1'b1;
    tick();

    // N_BITS=4, SETTLE_CYC=2, win_len=3: done at 34, sr_en at 8/16/24/32.
    run_model("t2", 1'b0, 2, 3, 4, 40);
    // SETTLE_CYC=0, win_len=0: three cycles per bit.
    run_model("t6", 1'b1, 0, 0, 4, 16);
    // Full-range window: ref_cnt 0..255 then capture, no wrap.
    run_model("t3", 1'b0, 2, 255, 4, 1045);

    // Abort together with start during bit 2 measure.
    ifa.win_len = 8'd3;
    ifa.start   = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      check_eq($sformatf("t4 c%0d", c), 32'(obs_a), 32'(model(c, 2, 3, 4)));
    end
    ifa.abort = 1'b1;
    tick();
    check_eq("t4 abort", 32'(obs_a), 32'h0000_0009);
    ifa.abort = 1'b0;
    ifa.start = 1'b0;
    tick();
    check_eq("t4 idle", 32'(obs_a), 32'h0000_0008);
    ifa.abort = 1'b1;
    tick();
    check_eq("t4 idle_abort", 32'(obs_a), 32'h0000_0008);
    ifa.abort = 1'b0;
    tick();

    // Continuous mode: two runs, win_len change in run 1 takes effect in run 2.
    dcnt        = 0;
    ifa.win_len = 8'd3;
    ifa.cont    = 1'b1;
    ifa.start   = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      if (c == 10) ifa.win_len = 8'd1;
      if (c == 40) ifa.cont = 1'b0;
      tick();
      if (ifa.done) dcnt++;
      check_eq($sformatf("t5 c%0d", c), 32'(obs_a),
               32'((c <= 34) ? model(c, 2, 3, 4) : model(c - 34, 2, 1, 4)));
    end
    check_eq("t5 dones", 32'(dcnt), 32'd2);
    ifa.start = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of a measure window.
    ifa.win_len = 8'd3;
    ifa.start   = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    check_eq("t1 pre", 32'(obs_a), 32'(model(5, 2, 3, 4)));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t1 async", 32'(obs_a), 32'h0000_0008);
    ifa.start = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("t1 after", 32'(obs_a), 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
